// File: rtl/if_fetch_queue.sv
// Decoupling queue between the I-cache response and ID. Accepts up to FETCH_WIDTH
// instructions per cycle, delivers one per cycle, and supports flush and refetch tagging.
module if_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int EXC_W       = 19
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     mem_refetch,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_instr,
  input  logic [FETCH_WIDTH-1:0]   in_mask,
  input  logic [EXC_W-1:0]         in_except,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [EXC_W-1:0]         out_except,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem   [DEPTH];

  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [AW-1:0]    rd_idx, wr_idx;
  logic             enq, deq;
  logic [PW-1:0]    n_write;
  logic [DEPTH-1:0] live;
  logic [EXC_W-1:0] enq_except;

  assign rd_idx     = rd_ptr[AW-1:0];
  assign wr_idx     = wr_ptr[AW-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign in_ready   = (count <= PW'(DEPTH - FETCH_WIDTH));
  assign out_valid  = (count != '0);
  assign enq        = in_valid && in_ready && !flush;
  assign deq        = out_valid && out_ready && !flush;
  assign enq_except = in_except | {mem_refetch, {(EXC_W-1){1'b0}}};

  assign out_pc     = pc_mem[rd_idx];
  assign out_instr  = instr_mem[rd_idx];
  assign out_except = exc_mem[rd_idx];

  // A faulting fetch collapses to a single lane-0 entry; otherwise one entry per mask bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    n_write = '0;
    if (in_except != '0) begin
      n_write = PW'(1);
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        n_write = n_write + PW'(in_mask[k]);
      end
    end
  end

  // An entry is resident when its distance from the head is below the occupancy.
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = ({1'b0, AW'(i) - rd_idx} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      // NOTE: storage is reset too, so the head payload reads 0 rather than X after reset.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        exc_mem[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later write to the same slot wins.
      if (mem_refetch) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (live[i]) exc_mem[i][EXC_W-1] <= 1'b1;
        end
      end
      if (enq) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          if (PW'(k) < n_write) begin
            pc_mem[wr_idx + AW'(k)]    <= in_pc + 32'(4 * k);
            instr_mem[wr_idx + AW'(k)] <= in_instr[32*k +: 32];
            exc_mem[wr_idx + AW'(k)]   <= enq_except;
          end
        end
        wr_ptr <= wr_ptr + n_write;
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a queue-based reference model predicts every
// delivered instruction; a monitor compares occupancy each cycle and payload on handshake.
module tb_if_fetch_queue;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int EXC_W = 19;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exc;
  } entry_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic              mem_refetch = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic [32*FW-1:0]  in_instr = '0;
  logic [FW-1:0]     in_mask = '0;
  logic [EXC_W-1:0]  in_except = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [EXC_W-1:0]  out_except;
  logic [CW-1:0]     count;

  entry_t exp_q[$];
  int     total = 0;
  int     passes = 0;
  bit     started = 1'b0;

  if_fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .EXC_W(EXC_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .mem_refetch(mem_refetch),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_mask(in_mask), .in_except(in_except), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_except(out_except), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of stimulus and advance the reference model by the same cycle.
  task automatic drive(input logic v, input logic [31:0] p, input logic [32*FW-1:0] ins,
                       input logic [FW-1:0] m, input logic [EXC_W-1:0] e,
                       input logic ordy, input logic fl, input logic rf, input logic rst_n);
    entry_t n;
    bit     head_leaves;
    @(negedge clk);
    #2;
    in_valid = v; in_pc = p; in_instr = ins; in_mask = m; in_except = e;
    out_ready = ordy; flush = fl; mem_refetch = rf; resetn = rst_n;
    head_leaves = (exp_q.size() != 0) && ordy;
    if (!rst_n || fl) begin
      exp_q.delete();
    end else begin
      if (rf) begin
        for (int i = head_leaves ? 1 : 0; i < exp_q.size(); i++) exp_q[i].exc[EXC_W-1] = 1'b1;
      end
      if (v && (exp_q.size() <= DEPTH - FW)) begin
        for (int k = 0; k < FW; k++) begin
          if ((e != '0) ? (k == 0) : m[k]) begin
            n.pc    = p + 32'(4 * k);
            n.instr = ins[32*k +: 32];
            n.exc   = e;
            if (rf) n.exc[EXC_W-1] = 1'b1;
            exp_q.push_back(n);
          end
        end
      end
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, '0, ordy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic resp(input logic [FW-1:0] m, input logic ordy, input logic rf);
    drive(1'b1, $urandom & 32'hFFFF_FFFC, {$urandom, $urandom}, m, '0, ordy, 1'b0, rf, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b0);
    check("drain_count", 64'(count), 64'(0));
  endtask

  // Monitor: occupancy checked early in the cycle, payload checked on each real handshake.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #1;
      if (started) begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() <= DEPTH - FW));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      end
      #2;
      if (started && resetn && out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL deq_unexpected: got pc 0x%0h, expected no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", 64'(out_pc), 64'(e.pc));
          check("out_instr", 64'(out_instr), 64'(e.instr));
          check("out_except", 64'(out_except), 64'(e.exc));
        end
      end
    end
  end

  initial begin
    logic [CW-1:0] c0;
    logic [FW-1:0] m;
    logic [EXC_W-1:0] ex;
    int nl;

    // Reset state
    drive(1'b1, 32'h1234, '1, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    started = 1'b1;
    idle(1'b0);
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    check("rst_out_except", 64'(out_except), 64'(0));

    // Basic flow
    drive(1'b1, 32'hBFC0_0000, {32'h2222_2222, 32'h1111_1111}, 2'b11, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("basic_pc0", 64'(out_pc), 64'(32'hBFC0_0000));
    check("basic_instr0", 64'(out_instr), 64'(32'h1111_1111));
    idle(1'b1);
    check("basic_pc1", 64'(out_pc), 64'(32'hBFC0_0004));
    check("basic_instr1", 64'(out_instr), 64'(32'h2222_2222));
    idle(1'b1);
    check("basic_empty", 64'(out_valid), 64'(0));

    // Fill and backpressure
    for (int i = 0; i < 5; i++) resp(2'b11, 1'b0, 1'b0);
    idle(1'b0);
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'(0));
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("drained2_in_ready", 64'(in_ready), 64'(1));
    drain();

    // Wrap across the last slot, then a faulting fetch
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) resp(2'b01, 1'b1, 1'b0);
    resp(2'b11, 1'b0, 1'b0);
    idle(1'b0);
    c0 = count;
    drive(1'b1, 32'h8000_0100, {$urandom, $urandom}, 2'b11, 19'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("exc_count_plus1", 64'(count), 64'(c0 + 1'b1));
    drain();

    // Flush priority over a concurrent enqueue, dequeue and refetch
    resp(2'b11, 1'b0, 1'b0);
    resp(2'b11, 1'b0, 1'b0);
    resp(2'b01, 1'b0, 1'b0);
    drive(1'b1, 32'h9000_0000, {$urandom, $urandom}, 2'b11, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));

    // Refetch tagging of resident and same-cycle entries
    resp(2'b11, 1'b0, 1'b0);
    resp(2'b01, 1'b0, 1'b0);
    resp(2'b11, 1'b0, 1'b1);
    resp(2'b01, 1'b0, 1'b0);
    drain();

    // Reset during simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++) resp(2'b11, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0000, {$urandom, $urandom}, 2'b11, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("mrst_count", 64'(count), 64'(0));
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_in_ready", 64'(in_ready), 64'(1));
    check("mrst_out_pc", 64'(out_pc), 64'(0));
    check("mrst_out_instr", 64'(out_instr), 64'(0));
    check("mrst_out_except", 64'(out_except), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      nl = $urandom_range(0, FW);
      m  = FW'((1 << nl) - 1);
      ex = '0;
      if ($urandom_range(0, 7) == 0) begin
        ex = EXC_W'($urandom_range(1, 255));
        if (m == '0) m = FW'(1);
      end
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, {$urandom, $urandom}, m, ex,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 7) == 0, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised decoupling queue between the instruction-cache response and the ID stage. It is the multi-issue successor to the single-entry IF pipeline register. Each cycle it accepts up to FETCH_WIDTH consecutive instructions sharing one fetch PC and one exception vector, and stores them per instruction. It delivers one instruction per cycle to ID, and supports whole-queue flush and MEM-driven refetch tagging of resident instructions.

## Interface
Parameters:
- DEPTH, 8: entries, one instruction each; power of two, at least 2*FETCH_WIDTH.
- FETCH_WIDTH, 2: instructions per fetch response; 1, 2 or 4.
- EXC_W, 19: width of the packed exception vector; bit EXC_W-1 is Refetch.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; one clock; synchronous, active-low.
- flush  in  1  discard all entries and any same-cycle enqueue.
- mem_refetch  in  1  set the Refetch bit on every resident and same-cycle-enqueued entry.
- in_valid  in  1  fetch response valid.
- in_ready  out  1  queue can take a full response: free slots >= FETCH_WIDTH.
- in_pc  in  32  PC of lane 0; lane k has PC in_pc + 4k, modulo 2^32.
- in_instr  in  32*FETCH_WIDTH  lane k occupies bits [32k+31:32k].
- in_mask  in  FETCH_WIDTH  valid lanes; contiguous from bit 0.
- in_except  in  EXC_W  exception vector applied to the response.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ID accepts the head (IF_Wr equivalent).
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction.
- out_except  out  EXC_W  head exception vector.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries, each holding {pc, instr, except}.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. count = wr_ptr - rd_ptr.
- Enqueue fires when in_valid && in_ready && !flush.
  - Lanes with in_mask set are written at wr_ptr, wr_ptr+1, … in lane order.
  - wr_ptr advances by popcount(in_mask).
  - Slot indices wrap modulo DEPTH.
  - If in_except != 0, only lane 0 is written, with pc in_pc, and wr_ptr advances by 1. The faulting fetch yields exactly one entry.
  - in_mask == 0 with in_valid: no write, no error.
- Dequeue fires when out_valid && out_ready && !flush; rd_ptr advances by 1.
- Simultaneous enqueue and dequeue are legal in the same cycle. in_ready is computed from the pre-dequeue count, so it is conservative.
- Flush:
  - Next cycle, rd_ptr = wr_ptr = 0 and count = 0.
  - A same-cycle enqueue is dropped.
  - Flush has priority over enqueue, dequeue and mem_refetch.
- Refetch:
  - While mem_refetch = 1 and flush = 0, every currently valid entry gets except[EXC_W-1] set.
  - Entries written in that cycle are stored with Refetch set.
  - Other exception bits are unchanged; the bit is sticky until dequeue.
- Outputs:
  - out_valid = (count != 0).
  - out_pc, out_instr and out_except come from the entry at rd_ptr.
  - With out_valid = 0, the payload is don't-care but must not be X after reset. Storage resets to 0.

## Timing
- Reset (resetn = 0 at a clk edge):
  - pointers 0, count 0, out_valid 0, in_ready 1.
  - out_pc, out_instr and out_except are 0.
  - Reset overrides everything, including mid-enqueue.
- Enqueue-to-output latency is 1 cycle: a response accepted at edge N is visible on out_* after edge N. There is no combinational in-to-out bypass.
- in_ready depends only on registered count, with no combinational path from in_valid or out_ready.
- Back-to-back: full throughput of FETCH_WIDTH in per cycle while space allows, and one out per cycle.
- Full: count > DEPTH-FETCH_WIDTH drives in_ready = 0. A partial-mask response is still refused while in_ready = 0.
- Empty: out_valid = 0. out_ready is ignored.
- Wrap-around: a multi-lane write straddling index DEPTH-1→0 must place lanes in order across the boundary.

## Test plan
- Reset then basic flow: DEPTH=8, FETCH_WIDTH=2. Enqueue pc 0xBFC00000 with instr {0x11111111, 0x22222222} and mask 2'b11, holding out_ready = 1.
  - Next cycle: out_pc 0xBFC00000, out_instr 0x11111111.
  - Following cycle: out_pc 0xBFC00004, out_instr 0x22222222, then out_valid 0.
- Fill and backpressure: out_ready = 0, enqueue full-mask responses every cycle.
  - count steps 2, 4, 6.
  - in_ready drops once count = 8.
  - The fifth response is not accepted.
  - Draining 2 entries restores in_ready.
- Wrap and exception: advance pointers to wr index 7, then enqueue mask 2'b11.
  - Lanes land in slots 7 and 0, and dequeue in order.
  - Next, enqueue with in_except = 1 (bit 0) and mask 2'b11: count +1 only, and out_except = 1 with the lane-0 pc.
- Flush priority: with 5 entries queued, assert flush together with in_valid, out_ready and mem_refetch.
  - Next cycle: count 0, out_valid 0, in_ready 1.
  - No entry from the concurrent response appears.
- Refetch tagging: with 3 entries queued, assert mem_refetch for one cycle while enqueuing a 2-lane response.
  - All 5 entries dequeue with except[18] = 1.
  - A response enqueued afterwards has except[18] = 0.
- Reset mid-operation: assert resetn = 0 during simultaneous enqueue and dequeue with 6 entries queued.
  - After the edge: count 0, all outputs 0, in_ready 1.
